// File: rtl/conv_pkg.sv
// Shared definitions for the 1-D streaming convolution engine.
//   conv_state_t : row-sequencing FSM states
//   DEF_*        : default parameter values used by the engine and its datapath
//   sum_width()  : full-precision accumulator width for a K-tap signed dot product
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_t;

    localparam int DEF_PIX_W = 8;
    localparam int DEF_W_W   = 8;
    localparam int DEF_N_PIX = 32;
    localparam int DEF_K     = 3;
    localparam int DEF_OUT_W = 18;

    // Product width plus enough growth bits to add K products without overflow.
    function automatic int sum_width(input int pix_w, input int w_w, input int k);
        return pix_w + w_w + $clog2(k);
    endfunction

endpackage

// File: rtl/conv_dot_sat.sv
// Combinational K-tap signed dot product.
//   window  : K pixels, tap i at [i*PIX_W +: PIX_W] (tap 0 = oldest pixel)
//   kernel  : K weights, tap i at [i*W_W +: W_W]
//   relu_en : clamp negative results to zero
//   result  : full-precision sum saturated to the OUT_W signed range, then ReLU
module conv_dot_sat
    import conv_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int W_W   = DEF_W_W,
    parameter int K     = DEF_K,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic [K*PIX_W-1:0] window,
    input  logic [K*W_W-1:0]   kernel,
    input  logic               relu_en,
    output logic [OUT_W-1:0]   result
);

    localparam int PROD_W = PIX_W + W_W;
    localparam int SUM_W  = sum_width(PIX_W, W_W, K);
    // One bit wider than both the sum and the output so that the saturation
    // limits and the sum compare correctly whichever of the two is wider.
    localparam int EXT_W  = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;

    localparam logic signed [EXT_W-1:0] SAT_MAX_C = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN_C = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [PROD_W-1:0] pix_ext_s;
    logic signed [PROD_W-1:0] w_ext_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [SUM_W-1:0]  sum_s;
    logic signed [EXT_W-1:0]  ext_s;
    logic        [OUT_W-1:0]  sat_s;

    // Multiply-accumulate over all taps at full precision.
    always_comb begin
        pix_ext_s = '0;
        w_ext_s   = '0;
        prod_s    = '0;
        sum_s     = '0;
        for (int i = 0; i < K; i++) begin
            pix_ext_s = {{W_W{window[i*PIX_W+PIX_W-1]}}, window[i*PIX_W +: PIX_W]};
            w_ext_s   = {{PIX_W{kernel[i*W_W+W_W-1]}}, kernel[i*W_W +: W_W]};
            prod_s    = pix_ext_s * w_ext_s;
            sum_s     = sum_s + {{(SUM_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
        end
    end

    // Saturate to the output range, then apply the optional ReLU clamp.
    always_comb begin
        ext_s = {{(EXT_W-SUM_W){sum_s[SUM_W-1]}}, sum_s};
        if (ext_s > SAT_MAX_C) begin
            sat_s = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (ext_s < SAT_MIN_C) begin
            sat_s = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            sat_s = ext_s[OUT_W-1:0];
        end
        if (relu_en && sat_s[OUT_W-1]) begin
            result = '0;
        end else begin
            result = sat_s;
        end
    end

endmodule

// File: rtl/conv1d_stream_engine.sv
// Streaming 1-D convolution over one row of N_PIX signed pixels with a K-tap kernel.
// A row begins with start in IDLE (kernel and relu_en latched), pixels stream in
// through a valid/ready handshake, and N_PIX-K+1 results stream out through a
// valid/ready handshake with out_last on the final one; done pulses once after it.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : begin a row (honoured in IDLE only)
//   kernel_in, relu_en    : row configuration, latched on accepted start
//   in_valid/in_ready/in_data    : pixel input stream
//   out_valid/out_ready/out_data : result output stream, out_last marks final result
//   busy                  : row in progress (LOAD or DRAIN)
//   done                  : one-cycle pulse after the final result is consumed
module conv1d_stream_engine
    import conv_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int W_W   = DEF_W_W,
    parameter int N_PIX = DEF_N_PIX,
    parameter int K     = DEF_K,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [K*W_W-1:0]   kernel_in,
    input  logic               relu_en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIX_W-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = $clog2(N_PIX + 1);

    conv_state_t          state_r;
    conv_state_t          state_nxt_s;
    logic [CNT_W-1:0]     pix_cnt_r;
    logic [K*PIX_W-1:0]   window_r;
    logic [K*PIX_W-1:0]   window_nxt_s;
    logic [K*W_W-1:0]     kernel_r;
    logic                 relu_r;
    logic                 out_valid_r;
    logic [OUT_W-1:0]     out_data_r;
    logic                 out_last_r;
    logic                 busy_r;
    logic                 done_r;
    logic [OUT_W-1:0]     dot_s;
    logic                 start_acc_s;
    logic                 in_fire_s;
    logic                 out_fire_s;
    logic                 emit_s;
    logic                 last_pix_s;

    // A new pixel may only enter when the output slot is free or being drained
    // this cycle, so the registered result is never overwritten.
    assign in_ready     = (state_r == ST_LOAD) && (pix_cnt_r < CNT_W'(N_PIX))
                          && (!out_valid_r || out_ready);
    assign in_fire_s    = in_valid && in_ready;
    assign out_fire_s   = out_valid_r && out_ready;
    assign start_acc_s  = (state_r == ST_IDLE) && start;
    // The first K-1 pixels only fill the window.
    assign emit_s       = in_fire_s && (pix_cnt_r >= CNT_W'(K - 1));
    assign last_pix_s   = in_fire_s && (pix_cnt_r == CNT_W'(N_PIX - 1));
    // Shift toward tap 0 (oldest); the accepted pixel lands in tap K-1.
    assign window_nxt_s = {in_data, window_r[K*PIX_W-1:PIX_W]};

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign done      = done_r;

    conv_dot_sat #(
        .PIX_W (PIX_W),
        .W_W   (W_W),
        .K     (K),
        .OUT_W (OUT_W)
    ) u_dot (
        .window  (window_nxt_s),
        .kernel  (kernel_r),
        .relu_en (relu_r),
        .result  (dot_s)
    );

    // Next-state logic for row sequencing.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (last_pix_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (out_fire_s && out_last_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register plus busy/done status decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_DRAIN);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Row configuration latch, pixel counter and pixel window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kernel_r  <= '0;
            relu_r    <= 1'b0;
            pix_cnt_r <= '0;
            window_r  <= '0;
        end else if (start_acc_s) begin
            kernel_r  <= kernel_in;
            relu_r    <= relu_en;
            pix_cnt_r <= '0;
            window_r  <= '0;
        end else if (in_fire_s) begin
            pix_cnt_r <= pix_cnt_r + CNT_W'(1);
            window_r  <= window_nxt_s;
        end
    end

    // Output holding register: loads a result one cycle after its last pixel,
    // holds it under backpressure and empties when consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
        end else if (emit_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= dot_s;
            out_last_r  <= last_pix_s;
        end else if (out_fire_s) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv1d_stream_engine.sv
module tb_conv1d_stream_engine;

    localparam int PIX_W = 8;
    localparam int W_W   = 8;
    localparam int N_PIX = 32;
    localparam int K     = 3;
    localparam int OUT_W = 18;
    localparam int BUDGET = 3000;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic [K*W_W-1:0] kernel_in;
    logic relu_en;
    logic in_valid;
    logic [PIX_W-1:0] in_data;
    logic out_ready;

    logic in_ready, out_valid, out_last, busy, done;
    logic signed [OUT_W-1:0] out_data;
    logic in_ready10, out_valid10, out_last10, busy10, done10;
    logic signed [9:0] out_data10;

    int n_checks = 0;
    int n_fail   = 0;
    int pix_a  [N_PIX];
    int exp_a  [N_PIX];
    int exp10_a[N_PIX];
    int n_exp = N_PIX - K + 1;
    int kw[K];
    bit relu_m = 1'b0;

    always #5 clk = ~clk;

    conv1d_stream_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .kernel_in(kernel_in), .relu_en(relu_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    conv1d_stream_engine #(.OUT_W(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start), .kernel_in(kernel_in), .relu_en(relu_en),
        .in_valid(in_valid), .in_ready(in_ready10), .in_data(in_data),
        .out_valid(out_valid10), .out_ready(out_ready), .out_data(out_data10),
        .out_last(out_last10), .busy(busy10), .done(done10)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: sum of products at full precision, clamp to outw bits, then ReLU.
    function automatic int model(input int j, input int outw);
        longint s;
        longint mx;
        longint mn;
        s = 0;
        for (int i = 0; i < K; i++) s += longint'(kw[i]) * longint'(pix_a[j+i]);
        mx = (longint'(1) <<< (outw - 1)) - 1;
        mn = -(mx + 1);
        if (s > mx) s = mx;
        else if (s < mn) s = mn;
        if (relu_m && s < 0) s = 0;
        return int'(s);
    endfunction

    task automatic set_kernel(input int a0, input int a1, input int a2);
        logic [W_W-1:0] t;
        kw[0] = a0; kw[1] = a1; kw[2] = a2;
        for (int i = 0; i < K; i++) begin
            t = kw[i][W_W-1:0];
            kernel_in[i*W_W +: W_W] = t;
        end
    endtask

    task automatic compute_exp();
        for (int j = 0; j < n_exp; j++) begin
            exp_a[j]   = model(j, OUT_W);
            exp10_a[j] = model(j, 10);
        end
    endtask

    task automatic start_row(input bit relu);
        relu_en = relu;
        relu_m  = relu;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("busy_after_start", busy, 1);
    endtask

    // Drives pixels and consumes results; mode 1 = out_ready always high, mode 2 = random.
    task automatic run_row(input int feed_cnt, input int mode, input int pulse_at);
        int pi = 0;
        int k = 0;
        int cyc = 0;
        int prev_idx = -1;
        bit hold_prev = 1'b0;
        bit infire, ofire;
        logic signed [OUT_W-1:0] data_prev = '0;
        while (((feed_cnt < N_PIX) ? (pi < feed_cnt) : (k < n_exp)) && cyc < BUDGET) begin
            out_ready = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            in_valid  = (pi < feed_cnt);
            if (pi < feed_cnt) in_data = pix_a[pi][PIX_W-1:0];
            else               in_data = '0;
            if (cyc == pulse_at) begin
                start = 1'b1; kernel_in = 24'h050505; relu_en = 1'b1;
            end else begin
                start = 1'b0;
            end
            #1;
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, data_prev);
            end
            if (out_valid && !out_ready) check("bp_in_ready", in_ready, 0);
            if (mode == 1) check("latency_valid", out_valid, (prev_idx >= K - 1));
            infire = in_valid && in_ready;
            ofire  = out_valid && out_ready;
            if (ofire) begin
                if (k < n_exp) begin
                    check($sformatf("data[%0d]", k), out_data, exp_a[k]);
                    check($sformatf("last[%0d]", k), out_last, (k == n_exp - 1));
                    check($sformatf("data10[%0d]", k), out_data10, exp10_a[k]);
                end else begin
                    check("extra_result", 1, 0);
                end
                k++;
            end
            hold_prev = out_valid && !out_ready;
            data_prev = out_data;
            prev_idx  = infire ? pi : -1;
            if (infire) pi++;
            cyc++;
            @(posedge clk);
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check("row_within_budget", (cyc < BUDGET), 1);
    endtask

    task automatic finish_row(input bit b2b);
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 0);
        check("no_valid_in_done", out_valid, 0);
        if (b2b) begin
            start = 1'b1; relu_en = 1'b0; relu_m = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check("done_clear", done, 0);
        if (b2b) begin
            check("b2b_ignored_in_done", busy, 0);
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            #1;
            check("b2b_accepted_idle", busy, 1);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; kernel_in = '0; relu_en = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp through a second-difference kernel: every result is zero.
        set_kernel(-1, 2, -1);
        for (int i = 0; i < N_PIX; i++) pix_a[i] = i;
        compute_exp();
        for (int j = 0; j < n_exp; j++) exp_a[j] = 0;
        start_row(1'b0);
        run_row(N_PIX, 1, -1);
        finish_row(1'b1);

        // Impulse row, started back-to-back; a start pulse mid-row must be ignored.
        for (int i = 0; i < N_PIX; i++) pix_a[i] = (i == 5) ? 10 : 0;
        compute_exp();
        for (int j = 0; j < n_exp; j++) exp_a[j] = 0;
        exp_a[3] = -10; exp_a[4] = 20; exp_a[5] = -10;
        run_row(N_PIX, 1, 3);
        finish_row(1'b0);

        // Asymmetric kernel, random pixels, random backpressure.
        set_kernel(3, -5, 7);
        for (int i = 0; i < N_PIX; i++) pix_a[i] = int'($urandom_range(0, 255)) - 128;
        compute_exp();
        start_row(1'b0);
        run_row(N_PIX, 2, -1);
        finish_row(1'b0);

        // Saturation at the narrow width, positive then negative, then ReLU.
        set_kernel(127, 127, 127);
        for (int i = 0; i < N_PIX; i++) pix_a[i] = 127;
        for (int j = 0; j < n_exp; j++) begin exp_a[j] = 48387; exp10_a[j] = 511; end
        start_row(1'b0);
        run_row(N_PIX, 2, -1);
        finish_row(1'b0);
        for (int i = 0; i < N_PIX; i++) pix_a[i] = -128;
        for (int j = 0; j < n_exp; j++) begin exp_a[j] = -48768; exp10_a[j] = -512; end
        start_row(1'b0);
        run_row(N_PIX, 1, -1);
        finish_row(1'b0);
        for (int j = 0; j < n_exp; j++) begin exp_a[j] = 0; exp10_a[j] = 0; end
        start_row(1'b1);
        run_row(N_PIX, 1, -1);
        finish_row(1'b0);

        // Reset part-way through a row, then a clean ramp row.
        set_kernel(-1, 2, -1);
        for (int i = 0; i < N_PIX; i++) pix_a[i] = i;
        compute_exp();
        for (int j = 0; j < n_exp; j++) exp_a[j] = 0;
        start_row(1'b0);
        run_row(13, 1, -1);
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_row(1'b0);
        run_row(N_PIX, 1, -1);
        finish_row(1'b0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
